// File: rtl/neighborhood_fetch_pkg.sv
// Shared types and constants for the five-pixel cross-window fetcher.
// Slot order is fixed: centre, up, down, left, right.
package neighborhood_fetch_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } state_e;

   localparam int unsigned SLOT_W = 3;

   localparam logic [SLOT_W-1:0] SLOT_C = 3'd0;
   localparam logic [SLOT_W-1:0] SLOT_U = 3'd1;
   localparam logic [SLOT_W-1:0] SLOT_D = 3'd2;
   localparam logic [SLOT_W-1:0] SLOT_L = 3'd3;
   localparam logic [SLOT_W-1:0] SLOT_R = 3'd4;

   localparam int unsigned LANE_W     = 8;
   localparam int unsigned WIN_W      = 5 * LANE_W;
   localparam int unsigned LANE_C_LSB = 32;
   localparam int unsigned LANE_U_LSB = 24;
   localparam int unsigned LANE_D_LSB = 16;
   localparam int unsigned LANE_L_LSB = 8;
   localparam int unsigned LANE_R_LSB = 0;

   // Zero never wins a max comparison against real pixels.
   localparam logic [LANE_W-1:0] DEFAULT_BORDER_VAL = 8'h00;

   function automatic int unsigned lane_lsb(input logic [SLOT_W-1:0] slot);
      int unsigned lsb;
      unique case (slot)
         SLOT_C:  lsb = LANE_C_LSB;
         SLOT_U:  lsb = LANE_U_LSB;
         SLOT_D:  lsb = LANE_D_LSB;
         SLOT_L:  lsb = LANE_L_LSB;
         default: lsb = LANE_R_LSB;
      endcase
      return lsb;
   endfunction

endpackage

// File: rtl/neighborhood_fetch_neighbor_addr_gen.sv
// Maps the registered centre address and coordinates plus a slot index to
// that slot's byte address and whether the pixel lies inside the image.
module neighbor_addr_gen
   import neighborhood_fetch_pkg::*;
#(
   parameter int unsigned IMG_W   = 320,
   parameter int unsigned IMG_H   = 240,
   parameter int unsigned COORD_W = 10
) (
   input  logic [31:0]        center_addr,
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   input  logic [SLOT_W-1:0]  slot,
   output logic [31:0]        slot_addr,
   output logic               in_bounds
);

   localparam logic [31:0] ROW_STRIDE = 32'(IMG_W);
   localparam logic [31:0] LAST_COL   = 32'(IMG_W - 1);
   localparam logic [31:0] LAST_ROW   = 32'(IMG_H - 1);

   logic [31:0] cx_ext;
   logic [31:0] cy_ext;

   assign cx_ext = 32'(cx);
   assign cy_ext = 32'(cy);

   always_comb begin
      slot_addr = center_addr;
      in_bounds = 1'b1;
      unique case (slot)
         SLOT_C: begin
            slot_addr = center_addr;
            in_bounds = 1'b1;
         end
         SLOT_U: begin
            slot_addr = center_addr - ROW_STRIDE;
            in_bounds = (cy_ext != 32'd0);
         end
         SLOT_D: begin
            slot_addr = center_addr + ROW_STRIDE;
            in_bounds = (cy_ext < LAST_ROW);
         end
         SLOT_L: begin
            slot_addr = center_addr - 32'd1;
            in_bounds = (cx_ext != 32'd0);
         end
         SLOT_R: begin
            slot_addr = center_addr + 32'd1;
            in_bounds = (cx_ext < LAST_COL);
         end
         default: begin
            slot_addr = center_addr;
            in_bounds = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/neighborhood_fetch.sv
// Fetches a centre pixel and its four cross neighbours byte-by-byte from image
// memory, substitutes a border value off-image, and presents the packed window.
module neighborhood_fetch
   import neighborhood_fetch_pkg::*;
#(
   parameter int unsigned        IMG_W      = 320,
   parameter int unsigned        IMG_H      = 240,
   parameter int unsigned        COORD_W    = 10,
   parameter logic [LANE_W-1:0]  BORDER_VAL = DEFAULT_BORDER_VAL
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [31:0]        base_addr,
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   output logic               busy,
   output logic               mem_rd,
   output logic [31:0]        mem_addr,
   input  logic               mem_ack,
   input  logic [7:0]         mem_rdata,
   output logic               win_valid,
   input  logic               win_ready,
   output logic [WIN_W-1:0]   window
);

   state_e              state_q, state_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [31:0]         center_q, center_d;
   logic [COORD_W-1:0]  cx_q, cx_d;
   logic [COORD_W-1:0]  cy_q, cy_d;
   logic                mem_rd_q, mem_rd_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [WIN_W-1:0]    window_q, window_d;

   logic [31:0]         slot_addr;
   logic                in_bounds;
   logic                lane_we;
   logic [LANE_W-1:0]   lane_data;

   neighbor_addr_gen #(
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H),
      .COORD_W (COORD_W)
   ) u_addr_gen (
      .center_addr (center_q),
      .cx          (cx_q),
      .cy          (cy_q),
      .slot        (slot_q),
      .slot_addr   (slot_addr),
      .in_bounds   (in_bounds)
   );

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      center_d   = center_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      mem_rd_d   = mem_rd_q;
      mem_addr_d = mem_addr_q;
      window_d   = window_q;
      lane_we    = 1'b0;
      lane_data  = BORDER_VAL;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               cx_d     = cx;
               cy_d     = cy;
               center_d = base_addr + 32'(cy) * 32'(IMG_W) + 32'(cx);
               slot_d   = SLOT_C;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            if (in_bounds) begin
               mem_rd_d   = 1'b1;
               mem_addr_d = slot_addr;
               state_d    = StWait;
            end else begin
               lane_we   = 1'b1;
               lane_data = BORDER_VAL;
            end
         end
         StWait: begin
            // Qualify with mem_rd so a stray ack can never complete a slot.
            if (mem_ack && mem_rd_q) begin
               lane_we   = 1'b1;
               lane_data = mem_rdata;
               mem_rd_d  = 1'b0;
            end
         end
         StDone: begin
            if (win_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (lane_we) begin
         window_d[lane_lsb(slot_q) +: LANE_W] = lane_data;
         if (slot_q == SLOT_R) begin
            state_d = StDone;
         end else begin
            slot_d  = slot_q + 3'd1;
            state_d = StIssue;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         slot_q     <= SLOT_C;
         center_q   <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         window_q   <= '0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         center_q   <= center_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         window_q   <= window_d;
      end
   end

   assign busy      = (state_q != StIdle);
   assign win_valid = (state_q == StDone);
   assign mem_rd    = mem_rd_q;
   assign mem_addr  = mem_addr_q;
   assign window    = window_q;

endmodule

// File: tb/tb_neighborhood_fetch.sv
// Directed bench for neighborhood_fetch on a 4x4 image; memory returns the
// low address byte. A second instance uses an 0xFF border value.
module tb_neighborhood_fetch;

   localparam int unsigned IMG_W   = 4;
   localparam int unsigned IMG_H   = 4;
   localparam int unsigned COORD_W = 10;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [31:0]        base_addr;
   logic [COORD_W-1:0] cx;
   logic [COORD_W-1:0] cy;
   logic               win_ready;

   logic               busy0, mem_rd0, mem_ack0, win_valid0;
   logic [31:0]        mem_addr0;
   logic [39:0]        window0;
   logic               busy1, mem_rd1, mem_ack1, win_valid1;
   logic [31:0]        mem_addr1;
   logic [39:0]        window1;

   int                 ack_delay;
   logic               force_ack;
   int                 cnt0, cnt1;

   int                 n_checks;
   int                 n_errors;

   logic [31:0]        reads[$];
   logic               prev_pending;
   logic [31:0]        prev_addr;
   int                 stab_err;

   neighborhood_fetch #(
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .COORD_W    (COORD_W),
      .BORDER_VAL (8'h00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .cx        (cx),
      .cy        (cy),
      .busy      (busy0),
      .mem_rd    (mem_rd0),
      .mem_addr  (mem_addr0),
      .mem_ack   (mem_ack0),
      .mem_rdata (mem_addr0[7:0]),
      .win_valid (win_valid0),
      .win_ready (win_ready),
      .window    (window0)
   );

   neighborhood_fetch #(
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .COORD_W    (COORD_W),
      .BORDER_VAL (8'hFF)
   ) dut_ff (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .cx        (cx),
      .cy        (cy),
      .busy      (busy1),
      .mem_rd    (mem_rd1),
      .mem_addr  (mem_addr1),
      .mem_ack   (mem_ack1),
      .mem_rdata (mem_addr1[7:0]),
      .win_valid (win_valid1),
      .win_ready (win_ready),
      .window    (window1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ack arrives after ack_delay cycles of a pending request.
   assign mem_ack0 = (mem_rd0 && (cnt0 == ack_delay)) || force_ack;
   assign mem_ack1 = (mem_rd1 && (cnt1 == ack_delay)) || force_ack;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0 <= 0;
         cnt1 <= 0;
      end else begin
         cnt0 <= (mem_rd0 && !mem_ack0) ? cnt0 + 1 : 0;
         cnt1 <= (mem_rd1 && !mem_ack1) ? cnt1 + 1 : 0;
      end
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         prev_pending <= 1'b0;
      end else begin
         if (mem_rd0 && mem_ack0) reads.push_back(mem_addr0);
         if (prev_pending && (!mem_rd0 || (mem_addr0 != prev_addr))) stab_err <= stab_err + 1;
         prev_pending <= mem_rd0 && !mem_ack0;
         prev_addr    <= mem_addr0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reads(input string tag, input logic [31:0] exp[$]);
      check({tag, " count"}, 64'(reads.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < reads.size(); i++) begin
         check($sformatf("%s addr%0d", tag, i), 64'(reads[i]), 64'(exp[i]));
      end
   endtask

   // Pulses start and counts edges (including the sampling edge) until win_valid.
   task automatic run_fetch(input logic [31:0] base, input int x, input int y,
                            input int glitch_at, output int lat);
      reads.delete();
      base_addr = base;
      cx        = COORD_W'(x);
      cy        = COORD_W'(y);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 1;
      while (!win_valid0 && lat < 300) begin
         if (lat == glitch_at) begin
            start = 1'b1;
            cx    = COORD_W'(2);
            cy    = COORD_W'(2);
         end
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
      end
   endtask

   task automatic handshake();
      win_ready = 1'b1;
      @(posedge clk); #1;
      win_ready = 1'b0;
   endtask

   initial begin
      int          lat;
      int          wcnt;
      logic [31:0] exp_int[$];
      logic [31:0] exp_corner[$];
      logic [31:0] exp_opp[$];

      n_checks  = 0;
      n_errors  = 0;
      stab_err  = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = 32'h0;
      cx        = '0;
      cy        = '0;
      win_ready = 1'b0;
      ack_delay = 0;
      force_ack = 1'b0;
      exp_int    = '{32'h105, 32'h101, 32'h109, 32'h104, 32'h106};
      exp_corner = '{32'h100, 32'h104, 32'h101};
      exp_opp    = '{32'h10F, 32'h10B, 32'h10E};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      check("reset busy",      64'(busy0),      64'd0);
      check("reset mem_rd",    64'(mem_rd0),    64'd0);
      check("reset mem_addr",  64'(mem_addr0),  64'd0);
      check("reset win_valid", 64'(win_valid0), 64'd0);
      check("reset window",    64'(window0),    64'd0);

      // Interior pixel, zero-wait memory.
      run_fetch(32'h100, 1, 1, -1, lat);
      check("int latency", 64'(lat), 64'd11);
      check("int window", 64'(window0), 64'h05_01_09_04_06);
      check_reads("int reads", exp_int);
      handshake();
      check("int post busy", 64'(busy0), 64'd0);
      check("int post valid", 64'(win_valid0), 64'd0);
      check("int idle hold", 64'(window0), 64'h05_01_09_04_06);

      // Top-left corner: up and left are off-image.
      run_fetch(32'h100, 0, 0, -1, lat);
      check("corner latency", 64'(lat), 64'd9);
      check("corner window", 64'(window0), 64'h00_00_04_00_01);
      check("corner window ff", 64'(window1), 64'h00_FF_04_FF_01);
      check_reads("corner reads", exp_corner);
      handshake();

      // Bottom-right corner: down and right are off-image.
      run_fetch(32'h100, 3, 3, -1, lat);
      check("opp latency", 64'(lat), 64'd9);
      check("opp window ff", 64'(window1), 64'h0F_0B_FF_0E_FF);
      check("opp window 00", 64'(window0), 64'h0F_0B_00_0E_00);
      check_reads("opp reads", exp_opp);
      handshake();

      // Three wait cycles per read.
      ack_delay = 3;
      stab_err  = 0;
      run_fetch(32'h100, 1, 1, -1, lat);
      check("wait latency", 64'(lat), 64'd26);
      check("wait window", 64'(window0), 64'h05_01_09_04_06);
      check("wait stability", 64'(stab_err), 64'd0);
      check_reads("wait reads", exp_int);
      handshake();
      ack_delay = 0;

      // Start pulsed mid-fetch must be ignored; then hold off win_ready.
      run_fetch(32'h200, 1, 1, 4, lat);
      check("bp latency", 64'(lat), 64'd11);
      check("bp window", 64'(window0), 64'h05_01_09_04_06);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp valid held", 64'(win_valid0), 64'd1);
         check("bp busy held", 64'(busy0), 64'd1);
         check("bp window held", 64'(window0), 64'h05_01_09_04_06);
      end
      check_reads("bp reads", '{32'h205, 32'h201, 32'h209, 32'h204, 32'h206});
      start     = 1'b1;
      win_ready = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      win_ready = 1'b0;
      check("bp done valid", 64'(win_valid0), 64'd0);
      check("bp done busy", 64'(busy0), 64'd0);
      @(posedge clk); #1;
      check("bp no restart", 64'(busy0), 64'd0);

      // Reset while waiting on the down-neighbour read.
      ack_delay = 3;
      reads.delete();
      base_addr = 32'h100;
      cx        = COORD_W'(1);
      cy        = COORD_W'(1);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wcnt  = 0;
      while (!(mem_rd0 && mem_addr0 == 32'h109) && wcnt < 60) begin
         @(posedge clk); #1;
         wcnt++;
      end
      check("rst reached slot2", 64'(mem_addr0), 64'h109);
      rst_n = 1'b0;
      #1;
      check("rst busy", 64'(busy0), 64'd0);
      check("rst mem_rd", 64'(mem_rd0), 64'd0);
      check("rst mem_addr", 64'(mem_addr0), 64'd0);
      check("rst valid", 64'(win_valid0), 64'd0);
      check("rst window", 64'(window0), 64'd0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      ack_delay = 0;
      force_ack = 1'b1;
      @(posedge clk); #1;
      force_ack = 1'b0;
      @(posedge clk); #1;
      check("late ack busy", 64'(busy0), 64'd0);
      check("late ack mem_rd", 64'(mem_rd0), 64'd0);
      check("late ack window", 64'(window0), 64'd0);
      run_fetch(32'h100, 0, 0, -1, lat);
      check("refetch latency", 64'(lat), 64'd9);
      check("refetch window", 64'(window0), 64'h00_00_04_00_01);
      check_reads("refetch reads", exp_corner);
      handshake();
      check("refetch ff busy", 64'(busy1), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
